// File: rtl/sw_debounce8.sv
// -----------------------------------------------------------------------------
// sw_debounce8
//
// Eight-channel switch debouncer that feeds a downstream 8-to-3 priority
// encoder. Each raw switch bit is brought into the clk domain with a two-flop
// synchronizer. It then gets its own stability counter. The debounced level x[i]
// only follows the synchronized level once that level has disagreed with x[i]
// for STABLE_CYCLES consecutive cycles. Any cycle of agreement restarts the
// count, so bounces shorter than STABLE_CYCLES never reach x.
//
// Parameters
//   STABLE_CYCLES  consecutive disagreeing cycles needed to update x (2..65535)
//   CNT_W          counter width, 2**CNT_W must exceed STABLE_CYCLES
//
// Ports
//   clk    in   1  single clock, rising-edge
//   rst_n  in   1  asynchronous active-low reset
//   sw_in  in   8  raw, asynchronous, possibly bouncing switch levels
//   x      out  8  debounced, synchronized levels (encoder request vector)
//   en     out  1  OR of x (encoder enable), no added latency
//   rise   out  8  registered one-cycle pulse per bit on a debounced 0->1
//   fall   out  8  registered one-cycle pulse per bit on a debounced 1->0
//   chg    out  1  one-cycle pulse whenever any bit of x changes
// -----------------------------------------------------------------------------
module sw_debounce8 #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_in,
    output logic [7:0] x,
    output logic       en,
    output logic [7:0] rise,
    output logic [7:0] fall,
    output logic       chg
);

    // Terminal count. Reaching it while still disagreeing commits the new
    // level on that same edge, so the counter never goes past this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Synchronizer stages
    logic [7:0]       s1_q;
    logic [7:0]       s2_q;

    // Debounced state and edge pulses
    logic [7:0]       x_q;
    logic [7:0]       x_d;
    logic [7:0]       rise_q;
    logic [7:0]       rise_d;
    logic [7:0]       fall_q;
    logic [7:0]       fall_d;

    // Per-bit stability counters
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // -------------------------------------------------------------------------
    // Per-bit next-state logic. Bits are fully independent: each one only
    // looks at its own synchronized input, its own x and its own counter.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            logic disagree;
            logic commit;

            assign disagree = s2_q[gi] ^ x_q[gi];
            assign commit   = disagree && (cnt_q[gi] == CNT_LAST);

            // Agreement (IDLE) or a commit both leave the counter at zero.
            assign cnt_d[gi]  = (!disagree || commit) ? '0 : cnt_q[gi] + CNT_W'(1);
            assign x_d[gi]    = commit ? s2_q[gi] : x_q[gi];

            // The pulses are registered alongside x, so they line up with the
            // first cycle in which x shows the new value.
            assign rise_d[gi] = commit &  s2_q[gi];
            assign fall_d[gi] = commit & ~s2_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sw_in;
            s2_q   <= s1_q;
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. en and chg are pure OR-reductions of registers, so they are
    // glitch-free and carry no extra cycle of latency. Reset clears all of
    // the registers, so releasing it cannot create a pulse.
    // -------------------------------------------------------------------------
    assign x    = x_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign en   = |x_q;
    assign chg  = |(rise_q | fall_q);

endmodule

// File: tb/tb_sw_debounce8.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce8
//
// Directed tests for sw_debounce8 with STABLE_CYCLES = 4. The expected values
// are worked out by hand from the counter rules. An input change is driven
// just after edge 0. The first edge that samples it is counted as edge 1. The
// input reaches s2 on edge 2, and the counter then reaches 1, 2 and 3 on edges
// 3, 4 and 5. The commit happens on edge 6.
//
// The final phase is a long randomized bounce run. It is compared every cycle
// against an independent behavioural model.
// -----------------------------------------------------------------------------
module tb_sw_debounce8;

    localparam int STABLE = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [7:0] x;
    logic       en;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;

    int n_checks = 0;
    int n_errors = 0;

    sw_debounce8 #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw_in),
        .x     (x),
        .en    (en),
        .rise  (rise),
        .fall  (fall),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so that both the
    // sampling and the input updates happen away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [7:0] ex, input logic [7:0] er,
                              input logic [7:0] ef, input logic ec, input logic ee);
        check_eq({tag, ".x"},    {24'd0, x},    {24'd0, ex});
        check_eq({tag, ".rise"}, {24'd0, rise}, {24'd0, er});
        check_eq({tag, ".fall"}, {24'd0, fall}, {24'd0, ef});
        check_eq({tag, ".chg"},  {31'd0, chg},  {31'd0, ec});
        check_eq({tag, ".en"},   {31'd0, en},   {31'd0, ee});
    endtask

    // Apply a clean step and verify that x is still the old value after edges
    // 1..5, commits on edge 6 with the pulses, and the pulses drop on edge 7.
    task automatic step_and_check(input string tag, input logic [7:0] old_x, input logic [7:0] new_sw);
        logic [7:0] r_exp;
        logic [7:0] f_exp;
        r_exp = new_sw & ~old_x;
        f_exp = ~new_sw & old_x;
        sw_in = new_sw;
        for (int k = 1; k <= STABLE + 1; k++) begin
            tick();
            expect_all($sformatf("%s.wait%0d", tag, k), old_x, 8'h00, 8'h00, 1'b0, |old_x);
        end
        tick();
        expect_all({tag, ".commit"}, new_sw, r_exp, f_exp, |(r_exp | f_exp), |new_sw);
        tick();
        expect_all({tag, ".after"}, new_sw, 8'h00, 8'h00, 1'b0, |new_sw);
    endtask

    // Reference model state for the random phase
    logic [7:0] m_s1, m_s2, m_x, m_rise, m_fall;
    int         m_run [8];

    initial begin
        logic [7:0] target;
        logic [7:0] drv;
        logic [7:0] noise;

        // ---- Reset held with all switches high, clock running ----
        rst_n = 1'b0;
        sw_in = 8'hFF;
        #1;
        expect_all("rst_async", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_all($sformatf("rst_hold%0d", k), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // ---- Release with inputs low: no pulses ----
        sw_in = 8'h00;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_all($sformatf("rel%0d", k), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // ---- Single clean rise on bit 3, then back down ----
        step_and_check("step08", 8'h00, 8'h08);
        tick();
        expect_all("hold08", 8'h08, 8'h00, 8'h00, 1'b0, 1'b1);
        step_and_check("fall08", 8'h08, 8'h00);

        // ---- Bounce on bit 2 shorter than STABLE cycles ----
        begin
            logic [2:0] pat [8];
            pat = '{3'b1, 3'b1, 3'b1, 3'b0, 3'b1, 3'b1, 3'b1, 3'b0};
            for (int k = 0; k < 8; k++) begin
                sw_in = {5'd0, pat[k][0], 2'd0};
                tick();
                expect_all($sformatf("bounce%0d", k), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            end
            for (int k = 0; k < 6; k++) begin
                tick();
                expect_all($sformatf("bounce_tail%0d", k), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            end
        end

        // ---- Two bits committing on the same edge, then a partial fall ----
        step_and_check("step81", 8'h00, 8'h81);
        step_and_check("step01", 8'h81, 8'h01);
        step_and_check("step00", 8'h01, 8'h00);

        // ---- Reset mid-count on bit 5 ----
        sw_in = 8'h20;
        for (int k = 0; k < 5; k++) tick();   // counter for bit 5 is now 3
        rst_n = 1'b0;
        #1;
        expect_all("midrst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;                          // next edge is first sampling edge
        step_and_check("post_rst20", 8'h00, 8'h20);
        step_and_check("post_rst00", 8'h20, 8'h00);

        // ---- Randomized bounce against the reference model ----
        rst_n = 1'b0;
        sw_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        m_s1 = '0; m_s2 = '0; m_x = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        target = 8'h00;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 99) < 4) target[i] = ~target[i];
            end
            if (cyc < 5000) noise = 8'($urandom & $urandom);
            else            noise = 8'($urandom & $urandom & $urandom & $urandom);
            drv   = target ^ noise;
            sw_in = drv;
            tick();

            // The model is evaluated on the values that were present before
            // the edge.
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_s2[i] == m_x[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 >= STABLE) begin
                    m_x[i]    = m_s2[i];
                    m_rise[i] = m_s2[i];
                    m_fall[i] = ~m_s2[i];
                    m_run[i]  = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
            m_s2 = m_s1;
            m_s1 = drv;

            check_eq("rnd.x",    {24'd0, x},    {24'd0, m_x});
            check_eq("rnd.rise", {24'd0, rise}, {24'd0, m_rise});
            check_eq("rnd.fall", {24'd0, fall}, {24'd0, m_fall});
            check_eq("rnd.chg",  {31'd0, chg},  {31'd0, |(m_rise | m_fall)});
            check_eq("rnd.en",   {31'd0, en},   {31'd0, |m_x});
            check_eq("rnd.rf_excl", {24'd0, rise & fall}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                check_eq("rnd.cnt_max", {31'd0, (dut.cnt_q[i] > 16'(STABLE - 1))}, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
